gcd_datapath: RTL and testbench
===============================

# gcd_datapath

Datapath partner of the GCD controller FSM. It receives the controller's `enable`, `sel`, `a_sel`, `b_sel`, `a_load`, `b_load` and `d_load` strobes, holds the two working operands, and performs subtract-and-compare steps. It returns the registered status flags `x_eq_y` and `x_greater_y` that drive the controller's branching, and it captures the final result with a one-cycle valid pulse, a subtraction count and a sticky underflow flag for diagnostics.

## Interface
- `WIDTH`, 8: operand, result and counter width in bits.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enable`  in  1  qualifies compare and subtract operations; operand loads from `x_in`/`y_in` ignore it.
- `sel`  in  2  operation select: 00 = A-B, 01 = B-A, 10 = compare, 11 = idle (hold).
- `a_sel`  in  1  A source when `a_load`=1: 0 = `x_in`, 1 = subtractor (A-B).
- `b_sel`  in  1  B source when `b_load`=1: 0 = `y_in`, 1 = subtractor (B-A).
- `a_load`  in  1  A write strobe.
- `b_load`  in  1  B write strobe.
- `d_load`  in  1  result capture request; level signal, edge-detected internally.
- `x_in`  in  WIDTH  first operand.
- `y_in`  in  WIDTH  second operand.
- `x_eq_y`  out  1  registered A==B from the last compare.
- `x_greater_y`  out  1  registered A>B from the last compare.
- `gcd_out`  out  WIDTH  result register D.
- `result_valid`  out  1  one-cycle pulse when D is written.
- `sub_count`  out  WIDTH  subtractions since the last operand load; saturates at 2^WIDTH-1.
- `underflow`  out  1  sticky; set on an attempted negative subtraction.

## Operation
- State: A, B, D (all WIDTH), flag registers, `d_load_q` (previous `d_load`), `sub_count`, `underflow`.

- A update, in priority order:
  1. `a_load`=1 and `a_sel`=0: A <= `x_in`.
  2. `a_load`=1, `a_sel`=1, `enable`=1, `sel`=00 and A>=B: A <= A-B, and `sub_count` increments.
  3. Same as (2) but A<B: A holds and `underflow` <= 1.
  4. Otherwise A holds.

- B update: symmetric to A, using `b_load`/`b_sel`, `y_in`, `sel`=01 and B-A.

- Operand loads:
  - Any A or B load from `x_in`/`y_in` clears `sub_count` and `underflow` on the same edge.
  - Flags are not cleared by operand loads.

- Compare: when `enable`=1 and `sel`=10, the flags update from the current A and B. Otherwise the flags hold.
  - `x_eq_y` <= (A==B).
  - `x_greater_y` <= (A>B).

- Result capture:
  - On `d_load`=1 and `d_load_q`=0: D <= A and `result_valid` <= 1.
  - Otherwise `result_valid` <= 0.
  - A held-high `d_load` produces exactly one pulse.

- Arithmetic: unsigned WIDTH-bit values. Subtraction never wraps; the A<B (or B<A) case is blocked and flagged instead.

- A zero operand is accepted. With one operand 0 and the other >0, the flags report (0,0) or (0,1) and any subtraction against the larger operand raises `underflow`.

## Timing
- All outputs reset to 0 asynchronously; A, B, D and `d_load_q` also reset to 0.
- Flags: 1-cycle latency, valid the edge after the compare cycle.
- Operand load to first valid compare: 2 edges (load edge, then compare edge).
- `result_valid`: high for exactly the cycle after the `d_load` rising edge. `gcd_out` is stable from that cycle until the next capture or reset.
- Simultaneous `a_load` and `b_load` with both subtract selects: only the arm matching `sel` acts; the other register holds.
- `sub_count` at saturation holds at 2^WIDTH-1 with no wrap.
- Reset asserted mid-computation: every register clears within the same cycle, with no clock needed. After reset deasserts, the block is idle until the next load.

## Test plan
- Load x=12, y=8, then compare/subtract sequence (A-B, B-A, A-B as flags dictate) -> flags (0,1) then (0,0) then (1,0). `d_load` rise gives `gcd_out`=4, one-cycle `result_valid`, `sub_count`=2.
- Load x=7, y=7, compare -> `x_eq_y`=1, `x_greater_y`=0. Capture gives `gcd_out`=7, `sub_count`=0.
- Load x=3, y=9; issue `sel`=00 with `a_sel`=1 -> A stays 3, `underflow`=1. A new operand load clears `underflow` and `sub_count`.
- Load x=255, y=1 and run to completion -> `gcd_out`=1, `sub_count`=254, no `underflow`.
- Hold `d_load` high for 5 cycles -> `result_valid` high exactly 1 cycle. Drop and re-raise `d_load` -> a second pulse.
- Assert `reset` between clock edges mid-run -> all outputs 0 immediately. Rerun with 12, 8 -> correct result `gcd_out`=4.

Source files
------------

// File: rtl/gcd_datapath.sv
// Purpose: operand registers, subtract/compare unit and result capture for the GCD controller.
// Latency: status flags, D, result_valid, sub_count and underflow all register one edge after their qualifying strobe.
// Backpressure: none; every strobe acts on the edge it is presented, and result_valid is a single-cycle pulse.
//
// Ports:
//   clock, reset           rising-edge clock; asynchronous active-high clear of all state
//   enable, sel            qualify and select the operation (00 A-B, 01 B-A, 10 compare, 11 hold)
//   a_sel/a_load           A write strobe and source (0 x_in, 1 A-B)
//   b_sel/b_load           B write strobe and source (0 y_in, 1 B-A)
//   d_load                 capture request level; only its rising edge writes D
//   x_in, y_in             operands
//   x_eq_y, x_greater_y    registered status of the last compare
//   gcd_out, result_valid  result register D and its one-cycle write pulse
//   sub_count, underflow   saturating subtraction count and sticky blocked-subtract flag
module gcd_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       sel,
  input  logic             a_sel,
  input  logic             b_sel,
  input  logic             a_load,
  input  logic             b_load,
  input  logic             d_load,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             x_eq_y,
  output logic             x_greater_y,
  output logic [WIDTH-1:0] gcd_out,
  output logic             result_valid,
  output logic [WIDTH-1:0] sub_count,
  output logic             underflow
);

  localparam logic [1:0] SEL_A_MINUS_B = 2'b00;
  localparam logic [1:0] SEL_B_MINUS_A = 2'b01;
  localparam logic [1:0] SEL_COMPARE   = 2'b10;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             d_load_q;

  logic a_ge_b;
  logic b_ge_a;
  logic a_raw_load;
  logic b_raw_load;
  logic a_sub_req;
  logic b_sub_req;
  logic a_sub_ok;
  logic b_sub_ok;
  logic sub_blocked;
  logic compare_en;
  logic capture;

  always_comb begin
    a_ge_b      = (a_q >= b_q);
    b_ge_a      = (b_q >= a_q);
    a_raw_load  = a_load & ~a_sel;
    b_raw_load  = b_load & ~b_sel;
    // A subtract request only exists for the arm whose direction matches sel,
    // so simultaneous subtract strobes never both act.
    a_sub_req   = a_load & a_sel & enable & (sel == SEL_A_MINUS_B);
    b_sub_req   = b_load & b_sel & enable & (sel == SEL_B_MINUS_A);
    a_sub_ok    = a_sub_req & a_ge_b;
    b_sub_ok    = b_sub_req & b_ge_a;
    // A negative result is never written; the attempt is recorded instead.
    sub_blocked = (a_sub_req & ~a_ge_b) | (b_sub_req & ~b_ge_a);
    compare_en  = enable & (sel == SEL_COMPARE);
    capture     = d_load & ~d_load_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_raw_load)    a_q <= x_in;
      else if (a_sub_ok) a_q <= a_q - b_q;

      if (b_raw_load)    b_q <= y_in;
      else if (b_sub_ok) b_q <= b_q - a_q;
    end
  end

  // A fresh operand starts a new diagnostic window, so a load clears the
  // counter and the sticky flag even if the other arm subtracts on that edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sub_count <= '0;
      underflow <= 1'b0;
    end else if (a_raw_load | b_raw_load) begin
      sub_count <= '0;
      underflow <= 1'b0;
    end else begin
      if ((a_sub_ok | b_sub_ok) && !(&sub_count)) sub_count <= sub_count + 1'b1;
      if (sub_blocked) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_eq_y      <= 1'b0;
      x_greater_y <= 1'b0;
    end else if (compare_en) begin
      x_eq_y      <= (a_q == b_q);
      x_greater_y <= (a_q > b_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_load_q     <= 1'b0;
      gcd_out      <= '0;
      result_valid <= 1'b0;
    end else begin
      d_load_q     <= d_load;
      result_valid <= capture;
      if (capture) gcd_out <= a_q;
    end
  end

endmodule

// File: tb/tb_gcd_datapath.sv
// Purpose: self-checking bench for gcd_datapath against a cycle-level arithmetic reference model.
// Latency: model state advances on each rising edge; outputs are sampled 1 time unit later.
// Backpressure: not applicable; the bench drives every strobe directly.
module tb_gcd_datapath;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [1:0]   sel = 2'b11;
  logic         a_sel = 1'b0;
  logic         b_sel = 1'b0;
  logic         a_load = 1'b0;
  logic         b_load = 1'b0;
  logic         d_load = 1'b0;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] y_in = '0;
  logic         x_eq_y;
  logic         x_greater_y;
  logic [W-1:0] gcd_out;
  logic         result_valid;
  logic [W-1:0] sub_count;
  logic         underflow;

  gcd_datapath #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sel(sel),
    .a_sel(a_sel), .b_sel(b_sel), .a_load(a_load), .b_load(b_load), .d_load(d_load),
    .x_in(x_in), .y_in(y_in),
    .x_eq_y(x_eq_y), .x_greater_y(x_greater_y), .gcd_out(gcd_out),
    .result_valid(result_valid), .sub_count(sub_count), .underflow(underflow)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state, as plain integers.
  int m_a, m_b, m_d, m_cnt;
  bit m_eq, m_gt, m_uf, m_rv, m_dq;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_d = 0; m_cnt = 0;
    m_eq = 0; m_gt = 0; m_uf = 0; m_rv = 0; m_dq = 0;
  endtask

  // One rising edge of the specified behaviour, applied to the current inputs.
  task automatic model_step();
    int  na = m_a;
    int  nb = m_b;
    int  subs = 0;
    bit  blocked = 0;
    bit  fresh = (a_load && !a_sel) || (b_load && !b_sel);
    if (a_load && !a_sel) na = x_in;
    else if (a_load && a_sel && enable && sel == 2'b00) begin
      if (m_a >= m_b) begin na = m_a - m_b; subs++; end
      else blocked = 1;
    end
    if (b_load && !b_sel) nb = y_in;
    else if (b_load && b_sel && enable && sel == 2'b01) begin
      if (m_b >= m_a) begin nb = m_b - m_a; subs++; end
      else blocked = 1;
    end
    if (fresh) begin
      m_cnt = 0;
      m_uf  = 0;
    end else begin
      m_cnt = (m_cnt + subs > MAX) ? MAX : m_cnt + subs;
      if (blocked) m_uf = 1;
    end
    if (enable && sel == 2'b10) begin
      m_eq = (m_a == m_b);
      m_gt = (m_a > m_b);
    end
    m_rv = d_load && !m_dq;
    if (m_rv) m_d = m_a;
    m_dq = d_load;
    m_a = na;
    m_b = nb;
  endtask

  task automatic check_outputs(input string where);
    check({where, ".x_eq_y"},       x_eq_y,       m_eq);
    check({where, ".x_greater_y"},  x_greater_y,  m_gt);
    check({where, ".gcd_out"},      gcd_out,      m_d);
    check({where, ".result_valid"}, result_valid, m_rv);
    check({where, ".sub_count"},    sub_count,    m_cnt);
    check({where, ".underflow"},    underflow,    m_uf);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle();
    enable = 0; sel = 2'b11; a_sel = 0; b_sel = 0;
    a_load = 0; b_load = 0; d_load = 0;
  endtask

  task automatic do_load(input int x, input int y);
    idle();
    a_load = 1; b_load = 1; x_in = W'(x); y_in = W'(y);
    cyc();
    idle();
  endtask

  task automatic do_cmp();
    idle(); enable = 1; sel = 2'b10; cyc(); idle();
  endtask

  task automatic do_sub_a();
    idle(); enable = 1; sel = 2'b00; a_load = 1; a_sel = 1; cyc(); idle();
  endtask

  task automatic do_sub_b();
    idle(); enable = 1; sel = 2'b01; b_load = 1; b_sel = 1; cyc(); idle();
  endtask

  task automatic do_capture();
    idle(); d_load = 1; cyc();
    check("capture.valid", result_valid, 1);
    idle(); cyc();
  endtask

  // Controller-style loop steered by the reference model; bounded so a
  // misbehaving DUT cannot hang the run.
  task automatic run_gcd(input int x, input int y);
    bit done = 0;
    int iter = 0;
    do_load(x, y);
    while (!done && iter < 600) begin
      do_cmp();
      if (m_eq) done = 1;
      else if (m_gt) do_sub_a();
      else do_sub_b();
      iter++;
    end
    if (!done) check("run.timeout", iter, 0);
    do_capture();
    check("run.gcd", gcd_out, ref_gcd(x, y));
    check("run.underflow", underflow, 0);
  endtask

  initial begin
    int pulses;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clock); #1;
    reset = 0;
    idle();

    // 12, 8: flags step through (0,1), (0,0), (1,0)
    do_load(12, 8);
    do_cmp();   check("g12.f1", {x_eq_y, x_greater_y}, 2'b01);
    do_sub_a();
    do_cmp();   check("g12.f2", {x_eq_y, x_greater_y}, 2'b00);
    do_sub_b();
    do_cmp();   check("g12.f3", {x_eq_y, x_greater_y}, 2'b10);
    do_capture();
    check("g12.gcd", gcd_out, 4);
    check("g12.cnt", sub_count, 2);

    // equal operands
    do_load(7, 7);
    do_cmp();   check("eq.f", {x_eq_y, x_greater_y}, 2'b10);
    do_capture();
    check("eq.gcd", gcd_out, 7);
    check("eq.cnt", sub_count, 0);

    // blocked subtraction, then cleared by a fresh load
    do_load(3, 9);
    do_sub_a();
    check("uf.set", underflow, 1);
    do_capture();
    check("uf.a_held", gcd_out, 3);
    do_load(5, 5);
    check("uf.clr", underflow, 0);
    check("uf.cnt_clr", sub_count, 0);

    // long run
    run_gcd(255, 1);
    check("long.cnt", sub_count, 254);

    // saturation: subtracting a zero B never blocks
    do_load(255, 0);
    for (int i = 0; i < 300; i++) do_sub_a();
    check("sat.cnt", sub_count, MAX);
    check("sat.uf", underflow, 0);
    do_sub_b();
    check("zero.uf", underflow, 1);
    do_cmp();
    check("zero.f", {x_eq_y, x_greater_y}, 2'b01);

    // held d_load yields one pulse, re-raise yields another
    for (int r = 0; r < 2; r++) begin
      pulses = 0;
      idle(); d_load = 1;
      for (int i = 0; i < 5; i++) begin
        cyc();
        if (result_valid) pulses++;
      end
      idle(); cyc();
      if (result_valid) pulses++;
      check("dload.pulses", pulses, 1);
    end

    // asynchronous reset mid-run
    do_load(40, 15);
    do_cmp();
    do_sub_a();
    #3;
    reset = 1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clock); #1;
    check_outputs("rst_hold");
    reset = 0;
    run_gcd(12, 8);
    check("rerun.gcd", gcd_out, 4);

    // random operand pairs through the controller loop
    for (int k = 0; k < 12; k++) run_gcd($urandom_range(1, MAX), $urandom_range(1, MAX));

    // unconstrained strobes each cycle, checked against the model
    for (int k = 0; k < 400; k++) begin
      enable = 1'($urandom_range(0, 1));
      sel    = 2'($urandom_range(0, 3));
      a_sel  = 1'($urandom_range(0, 1));
      b_sel  = 1'($urandom_range(0, 1));
      a_load = 1'($urandom_range(0, 1));
      b_load = 1'($urandom_range(0, 1));
      d_load = 1'($urandom_range(0, 1));
      x_in   = W'($urandom_range(0, MAX));
      y_in   = W'($urandom_range(0, MAX));
      // keep a fresh load from coinciding with a subtract on the other arm
      if (((a_load && !a_sel) || (b_load && !b_sel)) && sel != 2'b10) sel = 2'b11;
      cyc();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
